gate_bank: RTL and testbench
============================

Name: gate_bank

Overview:
- 4-bit bitwise logic-gate bank. Computes buffer, NOT, AND, NAND, OR, NOR, XOR and XNOR of two operand vectors.
- Drives the eight results as registered outputs.
- Used as a small combinational-function leaf behind one register stage. It is the reference block for gate-level regression vectors, 8 x 4-bit result fields per vector.

Parameters:
- WIDTH, 4, bit width of operands a, b and of every result output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a/b; operands are captured only when high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  high for the cycle(s) in which results reflect a captured operand pair.
- y  output  WIDTH  buffer of a.
- ynot  output  WIDTH  ~a.
- yand  output  WIDTH  a & b.
- ynand  output  WIDTH  ~(a & b).
- yor  output  WIDTH  a | b.
- ynor  output  WIDTH  ~(a | b).
- yxor  output  WIDTH  a ^ b.
- ynxor  output  WIDTH  ~(a ^ b).

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values: out_valid=0, and y, ynot, yand, ynand, yor, ynor, yxor, ynxor all 0. Note ynot/ynand/ynor/ynxor are also 0 in reset, not the inverse of 0.
- Reset has priority over in_valid on the same edge.
- Asserting reset mid-stream clears all outputs on that edge. The first capture after reset deasserts is the first edge with reset=0 and in_valid=1.
- Latency is 1 cycle. On edge N with in_valid=1, all eight results are computed from the a/b values present at edge N. They are visible after edge N, with out_valid=1.
- On an edge with in_valid=0, all result outputs hold their previous values and out_valid goes to 0.
- Back-to-back in_valid=1 gives one result per cycle; there is no backpressure.
- All functions are strictly bitwise. Bit i of each output depends only on bit i of a and bit i of b. There is no carry, no width growth and no truncation.
- All eight outputs update on the same edge; no output may lag another.
- X/Z on a or b while in_valid=0 must not affect outputs.
- Outputs are driven only from flops, with no combinational path from inputs to outputs.

Decomposition:
- Shared package gate_bank_pkg holds:
  - localparam default WIDTH=4;
  - typedef gate_res_t, a packed struct of the eight WIDTH-bit results in port order (y, ynot, yand, ynand, yor, ynor, yxor, ynxor);
  - a function computing gate_res_t from (a, b).
- One sub-module, gate_slice: a 1-bit combinational cell producing the eight 1-bit results. It is instantiated WIDTH times via generate.
- The top level holds the result register and the out_valid flop.

Test Plan:
- Reset: hold reset=1 for 2 cycles with a=4'hF, b=4'hF, in_valid=1 -> all outputs 0, out_valid=0.
- Mixed operands: a=4'b0101, b=4'b0011, in_valid=1 -> one cycle later y=0101, ynot=1010, yand=0001, ynand=1110, yor=0111, ynor=1000, yxor=0110, ynxor=1001, out_valid=1.
- Extremes: a=0000, b=1111 -> y=0000, ynot=1111, yand=0000, ynand=1111, yor=1111, ynor=0000, yxor=1111, ynxor=0000.
- Exhaustive: all 256 (a,b) pairs back-to-back with in_valid=1 -> every output matches the bitwise reference model one cycle later, with out_valid continuously 1.
- Hold: capture a=1100, b=1010, then drop in_valid and drive a=b=X for 3 cycles -> outputs stay yand=1000, yor=1110, yxor=0110, etc., with out_valid=0.
- Reset mid-stream: assert reset during continuous traffic -> all outputs 0 on that edge. Results resume one cycle after the first valid post-reset input.

Source files
------------

// File: rtl/gate_bank_pkg.sv
// Shared types for the gate bank: default width, result bundle, reference function.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package gate_bank_pkg;

    localparam int WIDTH = 4;

    // Eight bitwise results, in the same order as the top-level output ports.
    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] ynot;
        logic [WIDTH-1:0] yand;
        logic [WIDTH-1:0] ynand;
        logic [WIDTH-1:0] yor;
        logic [WIDTH-1:0] ynor;
        logic [WIDTH-1:0] yxor;
        logic [WIDTH-1:0] ynxor;
    } gate_res_t;

    function automatic gate_res_t gate_compute(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        gate_res_t r;
        r.y     = a;
        r.ynot  = ~a;
        r.yand  = a & b;
        r.ynand = ~(a & b);
        r.yor   = a | b;
        r.ynor  = ~(a | b);
        r.yxor  = a ^ b;
        r.ynxor = ~(a ^ b);
        return r;
    endfunction

endpackage

// File: rtl/gate_bank_slice.sv
// One-bit gate cell: buffer, NOT, AND, NAND, OR, NOR, XOR, XNOR of a and b.
// Latency: purely combinational.
// Backpressure: none.
module gate_slice (
    input  logic a,
    input  logic b,
    output logic y,
    output logic ynot,
    output logic yand,
    output logic ynand,
    output logic yor,
    output logic ynor,
    output logic yxor,
    output logic ynxor
);

    // All eight functions of the single bit pair.
    always_comb begin
        y     = a;
        ynot  = ~a;
        yand  = a & b;
        ynand = ~(a & b);
        yor   = a | b;
        ynor  = ~(a | b);
        yxor  = a ^ b;
        ynxor = ~(a ^ b);
    end

endmodule

// File: rtl/gate_bank.sv
// Bitwise gate bank: eight logic functions of a/b, registered with a valid flag.
// Latency: 1 cycle from an in_valid edge to results with out_valid=1.
// Backpressure: none; one result per cycle, results hold while in_valid is low.
module gate_bank
    import gate_bank_pkg::*;
#(
    parameter int WIDTH = gate_bank_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] ynot,
    output logic [WIDTH-1:0] yand,
    output logic [WIDTH-1:0] ynand,
    output logic [WIDTH-1:0] yor,
    output logic [WIDTH-1:0] ynor,
    output logic [WIDTH-1:0] yxor,
    output logic [WIDTH-1:0] ynxor
);

    // The result bundle type is sized by the package width, so WIDTH must
    // stay at the package default for the struct fields to line up.
    logic [WIDTH-1:0] s_y, s_ynot, s_yand, s_ynand;
    logic [WIDTH-1:0] s_yor, s_ynor, s_yxor, s_ynxor;

    gate_res_t res_d;
    gate_res_t res_q;
    logic      out_valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        gate_slice u_slice (
            .a     (a[i]),
            .b     (b[i]),
            .y     (s_y[i]),
            .ynot  (s_ynot[i]),
            .yand  (s_yand[i]),
            .ynand (s_ynand[i]),
            .yor   (s_yor[i]),
            .ynor  (s_ynor[i]),
            .yxor  (s_yxor[i]),
            .ynxor (s_ynxor[i])
        );
    end

    // Gather the per-bit slice outputs into the next-state result bundle.
    always_comb begin
        res_d       = '0;
        res_d.y     = s_y;
        res_d.ynot  = s_ynot;
        res_d.yand  = s_yand;
        res_d.ynand = s_ynand;
        res_d.yor   = s_yor;
        res_d.ynor  = s_ynor;
        res_d.yxor  = s_yxor;
        res_d.ynxor = s_ynxor;
    end

    // Capture on in_valid only, so undriven operands during idle never reach
    // the outputs; reset clears everything, inverted results included.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = res_q.y;
    assign ynot      = res_q.ynot;
    assign yand      = res_q.yand;
    assign ynand     = res_q.ynand;
    assign yor       = res_q.yor;
    assign ynor      = res_q.ynor;
    assign yxor      = res_q.yxor;
    assign ynxor     = res_q.ynxor;

endmodule

// File: tb/tb_gate_bank.sv
// Self-checking bench for gate_bank: directed scenarios plus randomized traffic.
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
// Expected values come from constants or a per-bit arithmetic truth model.
module tb_gate_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [3:0] y, ynot, yand, ynand, yor, ynor, yxor, ynxor;

    int checks = 0;
    int errors = 0;

    wire [31:0] got = {y, ynot, yand, ynand, yor, ynor, yxor, ynxor};

    always #5 clk = ~clk;

    gate_bank #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y),
        .ynot      (ynot),
        .yand      (yand),
        .ynand     (ynand),
        .yor       (yor),
        .ynor      (ynor),
        .yxor      (yxor),
        .ynxor     (ynxor)
    );

    // Truth-table model: bits treated as integers 0/1, functions via arithmetic.
    function automatic logic [31:0] ref_model(input logic [3:0] av, input logic [3:0] bv);
        logic [3:0] r [8];
        for (int i = 0; i < 4; i++) begin
            int ai, bi, p, s, x;
            ai = av[i] ? 1 : 0;
            bi = bv[i] ? 1 : 0;
            p  = ai * bi;
            s  = ai + bi - p;
            x  = (ai + bi) % 2;
            r[0][i] = (ai == 1);
            r[1][i] = (ai == 0);
            r[2][i] = (p == 1);
            r[3][i] = (p == 0);
            r[4][i] = (s == 1);
            r[5][i] = (s == 0);
            r[6][i] = (x == 1);
            r[7][i] = (x == 0);
        end
        return {r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]};
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (got !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %h exp %h", c, got, 32'h0);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid cycle %0d got %b exp 0", c, out_valid);
            end
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mixed();
        logic [31:0] exp;
        exp = {4'b0101, 4'b1010, 4'b0001, 4'b1110, 4'b0111, 4'b1000, 4'b0110, 4'b1001};
        a = 4'b0101; b = 4'b0011; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL mixed got %h exp %h", got, exp);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mixed_valid got %b exp 1", out_valid);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] exp;
        exp = {4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
        a = 4'b0000; b = 4'b1111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL extremes got %h exp %h", got, exp);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL extremes_valid got %b exp 1", out_valid);
        end
    endtask

    task automatic test_exhaustive();
        logic [31:0] exp;
        logic [7:0]  pair;
        in_valid = 1'b1;
        for (int k = 0; k < 257; k++) begin
            if (k > 0) begin
                pair = 8'(k - 1);
                exp  = ref_model(pair[7:4], pair[3:0]);
                checks++;
                if (got !== exp || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL exhaustive a=%h b=%h got %h/%b exp %h/1",
                             pair[7:4], pair[3:0], got, out_valid, exp);
                end
            end
            if (k < 256) begin
                pair = 8'(k);
                a = pair[7:4];
                b = pair[3:0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        logic [31:0] exp;
        exp = {4'b1100, 4'b0011, 4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001};
        a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (got !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_capture got %h/%b exp %h/1", got, out_valid, exp);
        end
        in_valid = 1'b0; a = 'x; b = 'x;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_outputs cycle %0d got %h exp %h", c, got, exp);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_valid cycle %0d got %b exp 0", c, out_valid);
            end
        end
        a = 4'h0; b = 4'h0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        logic [3:0]  ra, rb;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            a = 4'($urandom_range(15)); b = 4'($urandom_range(15));
            @(negedge clk);
        end
        reset = 1'b1;
        a = 4'hF; b = 4'h5;
        @(negedge clk);
        checks++;
        if (got !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %h/%b exp %h/0", got, out_valid, 32'h0);
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got %h/%b exp %h/0", got, out_valid, 32'h0);
        end
        ra = 4'b1001; rb = 4'b0110;
        a = ra; b = rb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        exp = ref_model(ra, rb);
        checks++;
        if (got !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_resume got %h/%b exp %h/1", got, out_valid, exp);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_res;
        logic        exp_vld;
        logic [3:0]  ra, rb;
        logic        riv;
        ra = 4'($urandom_range(15)); rb = 4'($urandom_range(15));
        a = ra; b = rb; in_valid = 1'b1;
        exp_res = ref_model(ra, rb);
        exp_vld = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            checks++;
            if (got !== exp_res || out_valid !== exp_vld) begin
                errors++;
                $display("FAIL random cycle %0d got %h/%b exp %h/%b",
                         c, got, out_valid, exp_res, exp_vld);
            end
            riv = ($urandom_range(3) != 0);
            ra  = 4'($urandom_range(15));
            rb  = 4'($urandom_range(15));
            in_valid = riv; a = ra; b = rb;
            if (riv) exp_res = ref_model(ra, rb);
            exp_vld = riv;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0;
        @(negedge clk);
        test_reset();
        test_mixed();
        test_extremes();
        test_exhaustive();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
